// File: rtl/spi_count_sequencer_if.sv
// -----------------------------------------------------------------------------
// spi_count_sequencer_if
// Byte handshake between the count sequencer and the SPI master.
//   tx_ready : master idle, may accept start          (master -> sequencer)
//   done     : one-cycle pulse, byte shift complete    (master -> sequencer)
//   start    : one-cycle request to send tx_data       (sequencer -> master)
//   tx_data  : byte to send, stable from start to done (sequencer -> master)
// Modport "master" is the sequencer side (it initiates the handshake),
// modport "slave" is the SPI master side.
// -----------------------------------------------------------------------------
interface spi_count_sequencer_if;
  logic       tx_ready;
  logic       done;
  logic       start;
  logic [7:0] tx_data;

  modport master (input tx_ready, input done, output start, output tx_data);
  modport slave  (output tx_ready, output done, input start, input tx_data);
endinterface

// File: rtl/spi_count_sequencer.sv
// -----------------------------------------------------------------------------
// spi_count_sequencer
// Run/stop up-counter (0..COUNT_MAX) stepped at TICK_HZ. Every change of the
// count (and every clear) is shipped to the SPI master as a frame:
//   byte0 = {2'b00, snap[13:8]}, byte1 = snap[7:0]
// Updates arriving while a frame is in flight coalesce into one follow-up
// frame carrying the latest count.
//
// Optional build macro SPI_SEQ_HEADER_EN: prefixes each frame with 0xA5.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   btn_runstop  : debounced pulse, toggles running
//   btn_clear    : debounced pulse, count := 0
//   spi          : handshake to the SPI master (tx_ready/done/start/tx_data)
//   count        : current counter value
//   running      : 1 while counting
//   busy         : 1 while a frame is in progress
// -----------------------------------------------------------------------------
module spi_count_sequencer #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned COUNT_MAX = 9999
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         btn_runstop,
  input  logic                         btn_clear,
  spi_count_sequencer_if.master        spi,
  output logic [13:0]                  count,
  output logic                         running,
  output logic                         busy
);

  localparam int unsigned   PRESC_MAX  = CLK_FREQ / TICK_HZ - 1;
  localparam int unsigned   PW         = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(PRESC_MAX);
  localparam logic [13:0]   CMAX       = 14'(COUNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef SPI_SEQ_HEADER_EN
    S_LOAD_HD,
    S_WAIT_HD,
`endif
    S_LOAD_HI,
    S_WAIT_HI,
    S_LOAD_LO,
    S_WAIT_LO
  } state_t;

  logic [PW-1:0] r_presc;
  logic [13:0]   r_count;
  logic          r_running;
  logic          r_pending;
  logic [13:0]   r_snap;
  logic          r_start;
  logic [7:0]    r_tx_data;
  state_t        r_state;

  logic          w_tick;
  logic [13:0]   w_count_nxt;
  logic          w_update;
  logic          w_take;
  logic          w_start_nxt;
  logic [7:0]    w_tx_nxt;
  state_t        w_state_nxt;

  // Clear wins over a same-cycle tick; a clear always counts as an update
  // even when the count is already zero.
  always_comb begin
    w_tick      = r_running && (r_presc == PRESC_TERM);
    w_count_nxt = r_count;
    if (btn_clear)
      w_count_nxt = '0;
    else if (w_tick)
      w_count_nxt = (r_count == CMAX) ? '0 : r_count + 14'd1;
    w_update = btn_clear || (w_count_nxt != r_count);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_running <= 1'b0;
      r_presc   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (btn_runstop)
        r_running <= ~r_running;
      if (btn_clear || !r_running || w_tick || btn_runstop)
        r_presc <= '0;
      else
        r_presc <= r_presc + PW'(1);
      // A new update in the cycle the frame is taken must survive.
      if (w_update)
        r_pending <= 1'b1;
      else if (w_take)
        r_pending <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_tx_nxt    = r_tx_data;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_take = 1'b1;
`ifdef SPI_SEQ_HEADER_EN
          w_state_nxt = S_LOAD_HD;
`else
          w_state_nxt = S_LOAD_HI;
`endif
        end
      end
`ifdef SPI_SEQ_HEADER_EN
      S_LOAD_HD: begin
        if (spi.tx_ready) begin
          w_start_nxt = 1'b1;
          w_tx_nxt    = 8'hA5;
          w_state_nxt = S_WAIT_HD;
        end
      end
      S_WAIT_HD: if (spi.done) w_state_nxt = S_LOAD_HI;
`endif
      S_LOAD_HI: begin
        if (spi.tx_ready) begin
          w_start_nxt = 1'b1;
          w_tx_nxt    = {2'b00, r_snap[13:8]};
          w_state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_HI: if (spi.done) w_state_nxt = S_LOAD_LO;
      S_LOAD_LO: begin
        if (spi.tx_ready) begin
          w_start_nxt = 1'b1;
          w_tx_nxt    = r_snap[7:0];
          w_state_nxt = S_WAIT_LO;
        end
      end
      S_WAIT_LO: if (spi.done) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_start   <= 1'b0;
      r_tx_data <= '0;
      r_snap    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start   <= w_start_nxt;
      r_tx_data <= w_tx_nxt;
      if (w_take)
        r_snap <= r_count;
    end
  end

  assign spi.start   = r_start;
  assign spi.tx_data = r_tx_data;
  assign count       = r_count;
  assign running     = r_running;
  assign busy        = (r_state != S_IDLE);

endmodule
